// File: rtl/seven_seg_scan_controller.sv
// Multiplexed common-anode seven-segment scan controller with double-buffered display data.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses anodes of leading zero digits.
module seven_seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    load_ack,
    output logic [3:0]              hex_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp_n,
    output logic                    frame_tick
);

    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] IDX_LAST   = DW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t                  state, state_n;
    logic [DW-1:0]           idx, idx_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [4*NUM_DIGITS-1:0] stg_data, stg_data_n, shd_data, shd_data_n;
    logic [NUM_DIGITS-1:0]   stg_dp, stg_dp_n, shd_dp, shd_dp_n;
    logic                    pending, pending_n;
    logic                    ack_n, tick_n, dp_n_n;
    logic [3:0]              hex_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    boundary, xfer_ok;

    // Next-state, buffer transfer and scan sequencing
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        stg_data_n = stg_data;
        stg_dp_n   = stg_dp;
        shd_data_n = shd_data;
        shd_dp_n   = shd_dp;
        pending_n  = pending;
        ack_n      = 1'b0;

        boundary = (state == DRIVE) && (cnt == CNT_LAST) && (idx == IDX_LAST);
        xfer_ok  = boundary || (state == IDLE);

        // A load that coincides with a transfer opportunity supersedes any staged data.
        if (xfer_ok && load) begin
            shd_data_n = data_in;
            shd_dp_n   = dp_in;
            pending_n  = 1'b0;
            ack_n      = 1'b1;
        end else if (xfer_ok && pending) begin
            shd_data_n = stg_data;
            shd_dp_n   = stg_dp;
            pending_n  = 1'b0;
            ack_n      = 1'b1;
        end else if (load) begin
            stg_data_n = data_in;
            stg_dp_n   = dp_in;
            pending_n  = 1'b1;
        end

        if (!enable) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = BLANK;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
                BLANK: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == BLANK_LAST) state_n = DRIVE;
                end
                DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // lz[i] is set when digits i..NUM_DIGITS-1 of the next shadow word are all zero.
    logic [NUM_DIGITS-1:0] lz;
    always_comb begin
        logic acc;
        acc = 1'b1;
        lz  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc   = acc && (shd_data_n[4*i +: 4] == 4'h0);
            lz[i] = acc;
        end
    end
`endif

    // Outputs are decoded from next-state values so the registered pins line up with the state.
    always_comb begin
        hex_n  = 4'h0;
        an_n   = '1;
        dp_n_n = 1'b1;
        tick_n = (state_n == DRIVE) && (cnt_n == CNT_LAST) && (idx_n == IDX_LAST);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_n == DW'(i)) begin
                hex_n = shd_data_n[4*i +: 4];
                if (state_n == DRIVE) begin
                    dp_n_n = ~shd_dp_n[i];
`ifdef LEADING_ZERO_BLANK_EN
                    an_n[i] = (i != 0) && lz[i];
`else
                    an_n[i] = 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            stg_data   <= '0;
            stg_dp     <= '0;
            shd_data   <= '0;
            shd_dp     <= '0;
            pending    <= 1'b0;
            load_ack   <= 1'b0;
            hex_out    <= 4'h0;
            an         <= '1;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            stg_data   <= stg_data_n;
            stg_dp     <= stg_dp_n;
            shd_data   <= shd_data_n;
            shd_dp     <= shd_dp_n;
            pending    <= pending_n;
            load_ack   <= ack_n;
            hex_out    <= hex_n;
            an         <= an_n;
            dp_n       <= dp_n_n;
            frame_tick <= tick_n;
        end
    end

endmodule
